// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// State encodings, port-select codes and the timer width helper live here.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DGNT = 2'd1,
        IGNT = 2'd2
    } arbState_t;

    localparam logic PORT_DATA  = 1'b0;
    localparam logic PORT_FETCH = 1'b1;

    function automatic int unsigned counterWidth(input int unsigned limit);
        return (limit > 32'd1) ? $clog2(limit) : 32'd1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Pipeline-side and memory-side signals of the arbiter, bundled as one interface.
// master = the arbiter itself, slave = the pipeline ports plus the memory.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_done;
    logic          if_stall;

    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic          dm_done;
    logic          dm_stall;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    logic          busy;
    logic          timeout_err;

    modport master (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               mem_req, mem_we, mem_addr, mem_wdata, busy, timeout_err
    );

    modport slave (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
               mem_req, mem_we, mem_addr, mem_wdata, busy, timeout_err
    );

endinterface

// File: rtl/mem_arbiter_timer.sv
// Wait-cycle counter for a granted access; expire is high while the count sits at TIMEOUT-1.
// The count saturates at the limit so a held enable never wraps back to zero.
module arb_timer
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);
    localparam int unsigned    CW    = counterWidth(TIMEOUT);
    localparam logic [CW-1:0]  LIMIT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Wait counter: cleared outside an access, counts stalled cycles up to the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= {CW{1'b0}};
        end else if (clear) begin
            count <= {CW{1'b0}};
        end else if (enable && !expire) begin
            count <= count + CW'(1);
        end else begin
            count <= count;
        end
    end

    assign expire = (count == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-ported, variable-latency memory between the fetch and data ports.
// Data wins ties; a port is ineligible in its own done cycle, so contention alternates.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.master bus
);
    arbState_t     state;
    arbState_t     nextState;

    logic          memReqReg,     memReqNext;
    logic          memWeReg,      memWeNext;
    logic [AW-1:0] memAddrReg,    memAddrNext;
    logic [DW-1:0] memWdataReg,   memWdataNext;
    logic [DW-1:0] ifRdataReg,    ifRdataNext;
    logic [DW-1:0] dmRdataReg,    dmRdataNext;
    logic          ifDoneReg,     ifDoneNext;
    logic          dmDoneReg,     dmDoneNext;
    logic          timeoutErrReg, timeoutErrNext;

    logic          dmEligible;
    logic          ifEligible;
    logic          servedPort;
    logic          expire;
    logic          timerClear;
    logic          timerEnable;

    // A request whose done is showing this cycle is the old, still-held one.
    assign dmEligible  = bus.dm_req & ~dmDoneReg;
    assign ifEligible  = bus.if_req & ~ifDoneReg;
    assign servedPort  = (state == IGNT) ? PORT_FETCH : PORT_DATA;

    assign timerClear  = (state == IDLE) | bus.mem_ready | expire;
    assign timerEnable = (state != IDLE) & ~bus.mem_ready;

    arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timerClear),
        .enable (timerEnable),
        .expire (expire)
    );

    // State and registered outputs; reset returns everything to a zeroed idle arbiter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            memReqReg     <= 1'b0;
            memWeReg      <= 1'b0;
            memAddrReg    <= {AW{1'b0}};
            memWdataReg   <= {DW{1'b0}};
            ifRdataReg    <= {DW{1'b0}};
            dmRdataReg    <= {DW{1'b0}};
            ifDoneReg     <= 1'b0;
            dmDoneReg     <= 1'b0;
            timeoutErrReg <= 1'b0;
        end else begin
            state         <= nextState;
            memReqReg     <= memReqNext;
            memWeReg      <= memWeNext;
            memAddrReg    <= memAddrNext;
            memWdataReg   <= memWdataNext;
            ifRdataReg    <= ifRdataNext;
            dmRdataReg    <= dmRdataNext;
            ifDoneReg     <= ifDoneNext;
            dmDoneReg     <= dmDoneNext;
            timeoutErrReg <= timeoutErrNext;
        end
    end

    // Next state: grant from IDLE, return to IDLE on completion or abort.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (dmEligible) begin
                    nextState = DGNT;
                end else if (ifEligible) begin
                    nextState = IGNT;
                end else begin
                    nextState = IDLE;
                end
            end
            DGNT, IGNT: begin
                if (bus.mem_ready || expire) begin
                    nextState = IDLE;
                end else begin
                    nextState = state;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Output register inputs: latch the winner, then capture data or abort with zeros.
    always_comb begin
        memReqNext     = memReqReg;
        memWeNext      = memWeReg;
        memAddrNext    = memAddrReg;
        memWdataNext   = memWdataReg;
        ifRdataNext    = ifRdataReg;
        dmRdataNext    = dmRdataReg;
        ifDoneNext     = 1'b0;
        dmDoneNext     = 1'b0;
        timeoutErrNext = timeoutErrReg;
        case (state)
            IDLE: begin
                if (dmEligible) begin
                    memReqNext   = 1'b1;
                    memWeNext    = bus.dm_we;
                    memAddrNext  = bus.dm_addr;
                    memWdataNext = bus.dm_wdata;
                end else if (ifEligible) begin
                    memReqNext   = 1'b1;
                    memWeNext    = 1'b0;
                    memAddrNext  = bus.if_addr;
                    memWdataNext = {DW{1'b0}};
                end else begin
                    memReqNext   = 1'b0;
                end
            end
            DGNT, IGNT: begin
                if (bus.mem_ready) begin
                    memReqNext = 1'b0;
                    if (servedPort == PORT_DATA) begin
                        dmDoneNext = 1'b1;
                        if (!memWeReg) begin
                            dmRdataNext = bus.mem_rdata;
                        end else begin
                            dmRdataNext = dmRdataReg;
                        end
                    end else begin
                        ifDoneNext  = 1'b1;
                        ifRdataNext = bus.mem_rdata;
                    end
                end else if (expire) begin
                    // Abort still pulses done so the stalled stage is released.
                    memReqNext     = 1'b0;
                    timeoutErrNext = 1'b1;
                    if (servedPort == PORT_DATA) begin
                        dmDoneNext  = 1'b1;
                        dmRdataNext = {DW{1'b0}};
                    end else begin
                        ifDoneNext  = 1'b1;
                        ifRdataNext = {DW{1'b0}};
                    end
                end else begin
                    memReqNext = 1'b1;
                end
            end
            default: begin
                memReqNext = 1'b0;
            end
        endcase
    end

    assign bus.mem_req     = memReqReg;
    assign bus.mem_we      = memWeReg;
    assign bus.mem_addr    = memAddrReg;
    assign bus.mem_wdata   = memWdataReg;
    assign bus.if_rdata    = ifRdataReg;
    assign bus.dm_rdata    = dmRdataReg;
    assign bus.if_done     = ifDoneReg;
    assign bus.dm_done     = dmDoneReg;
    assign bus.timeout_err = timeoutErrReg;
    assign bus.busy        = (state != IDLE);
    assign bus.if_stall    = bus.if_req & ~ifDoneReg;
    assign bus.dm_stall    = bus.dm_req & ~dmDoneReg;

endmodule
